// File: rtl/ssd_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssd_score_ctrl
// Purpose  : Two-player turn/score sequencer feeding a 4-digit SSD driver.
//            Holds BCD scores, the per-turn BCD countdown and the active
//            player, and registers d1..d4 / player / time_out / game_over.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_score_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int TURN_SEC  = 30,
    parameter int WIN_SCORE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       point_i,
    input  logic       pass_i,
    input  logic       show_time_i,
    output logic [3:0] d1_o,
    output logic [3:0] d2_o,
    output logic [3:0] d3_o,
    output logic [3:0] d4_o,
    output logic       player_o,
    output logic       time_out_o,
    output logic       game_over_o
);

    localparam int                CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  C_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]        C_TURN_BCD  = {4'(TURN_SEC / 10), 4'(TURN_SEC % 10)};
    localparam logic [6:0]        C_WIN       = 7'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       s0_q, s0_d;
    logic [7:0]       s1_q, s1_d;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             player_q, player_d;
    logic             to_q, to_d;
    logic             go_q;
    logic [7:0]       pair0_q, pair1_q;

    logic             w_tick;
    logic             w_expire;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       w_score_inc;
    logic             w_win;
    logic [7:0]       w_pair0, w_pair1;

    // BCD increment saturating at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)        return v;
        if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement, ones borrow from tens
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // BCD pair to binary value
    function automatic logic [6:0] bcd_val(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    assign w_tick      = (state_q != S_IDLE) && (cnt_q == C_TICK_LAST);
    assign w_cnt_next  = w_tick ? '0 : cnt_q + CNT_W'(1);
    assign w_expire    = w_tick && (timer_q == 8'h01);
    assign w_score_inc = bcd_inc(player_q ? s1_q : s0_q);
    assign w_win       = (bcd_val(w_score_inc) == C_WIN);

    // Next-state logic: game flow, scoring, countdown and turn hand-over
    always_comb begin
        state_d  = state_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        player_d = player_q;
        to_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d  = S_PLAY;
                    s0_d     = 8'h00;
                    s1_d     = 8'h00;
                    player_d = 1'b0;
                    timer_d  = C_TURN_BCD;
                end
            end
            S_PLAY: begin
                cnt_d = w_cnt_next;
                if (point_i) begin
                    if (player_q) s1_d = w_score_inc;
                    else          s0_d = w_score_inc;
                end
                // A winning point takes priority; any turn end that cycle is dropped
                if (point_i && w_win) begin
                    state_d = S_OVER;
                    phase_d = 1'b0;
                end else if (pass_i || w_expire) begin
                    player_d = ~player_q;
                    timer_d  = C_TURN_BCD;
                    cnt_d    = '0;
                    to_d     = w_expire;
                end else if (w_tick) begin
                    timer_d = bcd_dec(timer_q);
                end
            end
            S_OVER: begin
                cnt_d = w_cnt_next;
                if (w_tick) phase_d = ~phase_q;
                if (start_i) begin
                    state_d  = S_PLAY;
                    s0_d     = 8'h00;
                    s1_d     = 8'h00;
                    player_d = 1'b0;
                    timer_d  = C_TURN_BCD;
                    cnt_d    = '0;
                    phase_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Display contents derived from the current state (one cycle of latency)
    always_comb begin
        w_pair0 = s0_q;
        w_pair1 = s1_q;
        case (state_q)
            S_PLAY: begin
                if (show_time_i) begin
                    if (player_q) w_pair0 = timer_q;
                    else          w_pair1 = timer_q;
                end
            end
            S_OVER: begin
                if (phase_q) begin
                    if (player_q) w_pair1 = 8'hFF;
                    else          w_pair0 = 8'hFF;
                end
            end
            default: begin
                w_pair0 = 8'h00;
                w_pair1 = 8'h00;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s0_q     <= 8'h00;
            s1_q     <= 8'h00;
            timer_q  <= C_TURN_BCD;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            player_q <= 1'b0;
            to_q     <= 1'b0;
            go_q     <= 1'b0;
            pair0_q  <= 8'h00;
            pair1_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            player_q <= player_d;
            to_q     <= to_d;
            go_q     <= (state_d == S_OVER);
            pair0_q  <= w_pair0;
            pair1_q  <= w_pair1;
        end
    end

    assign d1_o        = pair0_q[7:4];
    assign d2_o        = pair0_q[3:0];
    assign d3_o        = pair1_q[7:4];
    assign d4_o        = pair1_q[3:0];
    assign player_o    = player_q;
    assign time_out_o  = to_q;
    assign game_over_o = go_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_score_ctrl
// Purpose  : Self-checking bench for ssd_score_ctrl (table vectors, directed
//            corner sequences, random stimulus against a decimal model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_score_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int TURN_SEC  = 3;
    localparam int WIN_SCORE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, point = 1'b0, pass = 1'b0, show = 1'b0;
    logic [3:0] d1, d2, d3, d4;
    logic       player, time_out, game_over;

    logic       b_start = 1'b0, b_point = 1'b0, b_show = 1'b0;
    logic       b_pass = 1'b0;
    logic [3:0] b_d1, b_d2, b_d3, b_d4;
    logic       b_player, b_time_out, b_game_over;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_score_ctrl #(.TICK_DIV(TICK_DIV), .TURN_SEC(TURN_SEC), .WIN_SCORE(WIN_SCORE)) dut (
        .clk(clk), .rst(rst), .start_i(start), .point_i(point), .pass_i(pass),
        .show_time_i(show), .d1_o(d1), .d2_o(d2), .d3_o(d3), .d4_o(d4),
        .player_o(player), .time_out_o(time_out), .game_over_o(game_over)
    );

    // Second build: two-digit turn length and unreachable-early win, for BCD carries
    ssd_score_ctrl #(.TICK_DIV(4), .TURN_SEC(12), .WIN_SCORE(99)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .point_i(b_point), .pass_i(b_pass),
        .show_time_i(b_show), .d1_o(b_d1), .d2_o(b_d2), .d3_o(b_d3), .d4_o(b_d4),
        .player_o(b_player), .time_out_o(b_time_out), .game_over_o(b_game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] outs();
        return {d1, d2, d3, d4, player, time_out, game_over};
    endfunction

    // ---------------- behavioural reference model (decimal) ----------------
    int       m_state;   // 0 idle, 1 play, 2 over
    int       m_s[2];
    int       m_timer;
    int       m_cnt;
    bit       m_phase;
    bit       m_player;
    bit       m_to;
    logic [18:0] m_out;

    function automatic logic [7:0] pair(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_s[0] = 0; m_s[1] = 0; m_timer = TURN_SEC;
        m_cnt = 0; m_phase = 0; m_player = 0; m_to = 0; m_out = '0;
    endtask

    task automatic new_game();
        m_state = 1; m_s[0] = 0; m_s[1] = 0; m_player = 0;
        m_timer = TURN_SEC; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit pt, input bit ps, input bit sh);
        logic [7:0] p0, p1;
        bit tick, expire;
        int nxt;
        p0 = pair(m_s[0]);
        p1 = pair(m_s[1]);
        if (m_state == 0) begin
            p0 = 8'h00; p1 = 8'h00;
        end else if (m_state == 1 && sh) begin
            if (m_player == 0) p1 = pair(m_timer); else p0 = pair(m_timer);
        end else if (m_state == 2 && m_phase) begin
            if (m_player == 0) p0 = 8'hFF; else p1 = 8'hFF;
        end
        tick = (m_state != 0) && (m_cnt == TICK_DIV - 1);
        nxt  = tick ? 0 : m_cnt + 1;
        m_to = 0;
        case (m_state)
            0: if (st) new_game();
            1: begin
                m_cnt = nxt;
                if (pt && m_s[m_player] < 99) m_s[m_player] = m_s[m_player] + 1;
                if (pt && m_s[m_player] == WIN_SCORE) begin
                    m_state = 2; m_phase = 0;
                end else begin
                    expire = tick && (m_timer == 1);
                    if (ps || expire) begin
                        m_player = ~m_player; m_timer = TURN_SEC; m_cnt = 0; m_to = expire;
                    end else if (tick) begin
                        m_timer = m_timer - 1;
                    end
                end
            end
            default: begin
                m_cnt = nxt;
                if (tick) m_phase = ~m_phase;
                if (st) new_game();
            end
        endcase
        m_out = {p0, p1, m_player, m_to, (m_state == 2)};
    endtask

    task automatic step(input bit st, input bit pt, input bit ps, input bit sh);
        start = st; point = pt; pass = ps; show = sh;
        @(posedge clk);
        model_step(st, pt, ps, sh);
        #1;
    endtask

    task automatic mstep(input string name, input bit st, input bit pt, input bit ps, input bit sh);
        step(st, pt, ps, sh);
        check(name, outs(), m_out);
    endtask

    task automatic bstep(input bit st, input bit pt, input bit sh);
        b_start = st; b_point = pt; b_show = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check(name, outs(), 19'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          st, pt, ps, sh;
        logic [18:0] exp;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit pt, input bit ps, input bit sh,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d,
                                input bit pl, input bit to, input bit go);
        vec_t v;
        v.st = st; v.pt = pt; v.ps = ps; v.sh = sh;
        v.exp = {a, b, c, d, pl, to, go};
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        bit found;
        model_reset();
        for (int i = 1; i <= 4; i++)  tbl[i] = mk(0,0,0,1, 0,0,0,3, 0,0,0);
        for (int i = 5; i <= 8; i++)  tbl[i] = mk(0,0,0,1, 0,0,0,2, 0,0,0);
        for (int i = 9; i <= 11; i++) tbl[i] = mk(0,0,0,1, 0,0,0,1, 0,0,0);
        tbl[0]  = mk(1,0,0,0, 0,0,0,0, 0,0,0);
        tbl[12] = mk(0,0,0,1, 0,0,0,1, 1,1,0);
        tbl[13] = mk(0,1,0,1, 0,3,0,0, 1,0,0);
        tbl[14] = mk(0,0,1,0, 0,0,0,1, 0,0,0);
        tbl[15] = mk(0,0,0,0, 0,0,0,1, 0,0,0);
        for (int i = 16; i <= 20; i++) tbl[i] = mk(0,1,0,0, 0,4'(i-16),0,1, 0,0,(i == 20));
        tbl[21] = mk(0,0,0,1, 0,5,0,1, 0,0,1);
        tbl[22] = mk(0,0,0,0, 0,5,0,1, 0,0,1);
        tbl[23] = mk(0,0,0,0, 4'hF,4'hF,0,1, 0,0,1);
        tbl[24] = mk(0,1,1,0, 4'hF,4'hF,0,1, 0,0,1);
        tbl[25] = mk(0,0,0,0, 4'hF,4'hF,0,1, 0,0,1);
        tbl[26] = mk(0,0,0,0, 4'hF,4'hF,0,1, 0,0,1);
        tbl[27] = mk(1,0,0,0, 0,5,0,1, 0,0,0);
        tbl[28] = mk(0,0,0,0, 0,0,0,0, 0,0,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", outs(), 19'h0);
        check("reset_b", {b_d1, b_d2, b_d3, b_d4, b_player, b_time_out, b_game_over}, 19'h0);
        @(negedge clk);
        rst = 1'b0;

        // BCD carry 09->10 and countdown borrow 10->09 on the second build
        bstep(1, 0, 0);
        repeat (10) bstep(0, 1, 0);
        bstep(0, 0, 0);
        check("b_score_carry", {b_d1, b_d2, b_d3, b_d4}, 16'h1000);
        bstep(0, 0, 1);
        check("b_timer_10", {b_d1, b_d2, b_d3, b_d4}, 16'h1010);
        bstep(0, 0, 1);
        check("b_timer_09", {b_d1, b_d2, b_d3, b_d4}, 16'h1009);
        b_show = 1'b0;

        // Table: countdown, expiry, pass, win, blink, restart
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].st, tbl[i].pt, tbl[i].ps, tbl[i].sh);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
        end

        // Point + pass + expiry in one cycle with P0 at 02
        mstep("simul_pt1", 0, 1, 0, 0);
        mstep("simul_pt2", 0, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_state == 1 && m_timer == 1 && m_cnt == TICK_DIV - 1) found = 1;
            else mstep("simul_wait", 0, 0, 0, 0);
        end
        check("simul_reach", 32'(found), 32'd1);
        mstep("simul_evt", 0, 1, 1, 0);
        check("simul_player", 32'(player), 32'd1);
        check("simul_timeout", 32'(time_out), 32'd1);
        mstep("simul_after", 0, 0, 0, 0);
        check("simul_p0_score", {d1, d2}, 8'h03);
        check("simul_to_drop", 32'(time_out), 32'd0);

        // Win with point and pass together, P0 at 04
        mstep("win_pass", 0, 0, 1, 0);
        mstep("win_pt4", 0, 1, 0, 0);
        mstep("win_evt", 0, 1, 1, 0);
        check("win_state", {player, game_over}, 2'b01);
        for (int i = 0; i < 10; i++) mstep("win_blink", 0, 0, 0, 1);

        // Async reset mid-game with P1 at 02
        mstep("rst_start", 1, 0, 0, 0);
        mstep("rst_pass", 0, 0, 1, 0);
        mstep("rst_pt1", 0, 1, 0, 0);
        mstep("rst_pt2", 0, 1, 0, 0);
        mstep("rst_show", 0, 0, 0, 0);
        check("rst_p1_score", {d3, d4}, 8'h02);
        pulse_reset("rst_mid_play");
        mstep("rst_idle", 0, 1, 1, 1);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rand_reset");
            end else begin
                mstep("random",
                      ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 1) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
